mcu_mem_ctrl: RTL and testbench
===============================

Name: mcu_mem_ctrl

Overview:
Parametrised unified program/data memory for the 8-bit CISC MCU, and the generational successor to the fixed 32-byte memory.
- Low address region: read-only program image.
- High address region: writable data RAM, filled from a default table by an init sequencer after reset or on request.
- Request qualification (ready), a registered read with a valid strobe, and address-error reporting.
- Sits between the CPU control unit and the memory bus.

Parameters:
DATA_W, 8, data word width
ADDR_W, 5, address width
ROM_DEPTH, 14, program words at addresses 0..ROM_DEPTH-1
RAM_BASE, 26, first data RAM address
RAM_DEPTH, 6, data RAM words at addresses RAM_BASE..RAM_BASE+RAM_DEPTH-1
ROM_IMAGE, mcu_mem_pkg::DEF_ROM, flattened ROM_DEPTH*DATA_W program image, word 0 in the LSBs
RAM_INIT, mcu_mem_pkg::DEF_RAM_INIT, flattened RAM_DEPTH*DATA_W init values, word 0 in the LSBs

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous active-high reset
init_req  in  1  one-cycle pulse that restarts the RAM init sequence
READ  in  1  read request
WRITE  in  1  write request
MEM_ADDR  in  ADDR_W  request address
MEM_DATA1  in  DATA_W  write data
MEM_DATA2  out  DATA_W  registered read data
ready  out  1  requests accepted when high
rd_valid  out  1  MEM_DATA2 updated by the read accepted on the previous edge
addr_err  out  1  one-cycle pulse on an illegal access

Behaviour:
- One clock, clk. Reset is synchronous and active-high on the port reset. All state updates on posedge clk.
- Reset values: MEM_DATA2=0, rd_valid=0, addr_err=0, ready=0, state=INIT, init_idx=0. RAM contents are not cleared by reset; INIT overwrites them.
- FSM has two states, INIT and RUN.
- INIT:
  - Each edge writes ram[init_idx] <= RAM_INIT word init_idx, then init_idx++.
  - On the edge that writes index RAM_DEPTH-1, the state moves to RUN and ready goes high.
  - Completion point: ready is first high after RAM_DEPTH edges with reset low.
  - READ and WRITE are ignored: no data change, no rd_valid, no addr_err.
- RUN: ready=1. A request is accepted on an edge where ready=1 and READ or WRITE is high.
- Read:
  - ROM address: MEM_DATA2 <= ROM word.
  - RAM address: MEM_DATA2 <= ram[addr-RAM_BASE].
  - Unmapped address: MEM_DATA2 <= 0 and addr_err pulses.
  - rd_valid is high for exactly the cycle after each accepted read, so latency is 1. Back-to-back reads give rd_valid high continuously.
  - MEM_DATA2 holds its value when no read is accepted.
- Write:
  - RAM address: ram word updated at that edge.
  - ROM or unmapped address: write dropped and addr_err pulses.
  - No rd_valid on a write.
- READ and WRITE both high: the read is performed and the write is discarded (read priority). addr_err is not raised for the discarded write.
- A write at edge N followed by a read of the same address at edge N+1 returns the new data.
- init_req in RUN: at the next edge the FSM enters INIT with init_idx=0, ready drops, and any request in that same cycle is ignored. init_req during INIT restarts init_idx at 0.
- reset mid-INIT or mid-RUN: returns to the reset values at that edge. A pending rd_valid is cancelled.
- Address arithmetic: RAM index = MEM_ADDR-RAM_BASE, taken as ADDR_W-bit unsigned. init_idx width is clog2(RAM_DEPTH), minimum 1.
- Elaboration checks, fatal on violation:
  - ROM_DEPTH <= RAM_BASE
  - RAM_BASE+RAM_DEPTH <= 2**ADDR_W
  - RAM_DEPTH >= 1

Decomposition:
- mcu_mem_pkg holds:
  - the state enum (INIT, RUN);
  - DEF_ROM = BF,5E,DA,BF,DE,BA,DF,BD,5B,DD,9C,20,E0,00 (hex, word 0 first);
  - DEF_RAM_INIT = 00,01,0A,00,01,01;
  - a region-decode function returning ROM/RAM/UNMAPPED.
- One sub-module, mcu_mem_init_seq, contains the INIT/RUN FSM, init_idx counter and ready generation. It drives the RAM write port mux select.

Test Plan:
1. Release reset, hold READ=1 at addr 0 → ready low for 6 cycles with no rd_valid. First accepted read returns MEM_DATA2=0xBF with rd_valid one cycle later.
2. After init, read addrs 26..31 back-to-back → 00,01,0A,00,01,01, with rd_valid high for 6 consecutive cycles.
3. WRITE 0x37 to addr 29, then READ 29 on the next edge → 0x37. WRITE 0x55 to addr 3 → addr_err pulse, and a later READ 3 returns 0xBF.
4. READ addr 20 (unmapped) → MEM_DATA2=0, rd_valid=1 and addr_err=1 for one cycle each. READ=WRITE=1 at addr 28 with data 0xFF → returns 0x0A and RAM stays 0x0A.
5. After writing 0x37 to addr 29, pulse init_req with a READ in the same cycle → read ignored and ready low 6 cycles. Afterwards addr 29 reads 0x00.
6. Assert reset during INIT (idx=3) and while rd_valid is pending → all outputs 0 next cycle and init restarts. Re-run with ADDR_W=6, RAM_BASE=40, RAM_DEPTH=8 and matching RAM_INIT to check generalisation.

Source files
------------

// File: rtl/mcu_mem_pkg.sv
// rtl/mcu_mem_pkg.sv - shared types, default memory images and region decode for mcu_mem_ctrl
package mcu_mem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } mem_state_e;

    typedef enum logic [1:0] {
        REG_ROM      = 2'd0,
        REG_RAM      = 2'd1,
        REG_UNMAPPED = 2'd2
    } mem_region_e;

    // Word 0 sits in the least significant byte.
    localparam logic [14*8-1:0] DEF_ROM = {
        8'h00, 8'hE0, 8'h20, 8'h9C, 8'hDD, 8'h5B, 8'hBD,
        8'hDF, 8'hBA, 8'hDE, 8'hBF, 8'hDA, 8'h5E, 8'hBF
    };

    localparam logic [6*8-1:0] DEF_RAM_INIT = {
        8'h01, 8'h01, 8'h00, 8'h0A, 8'h01, 8'h00
    };

    function automatic mem_region_e decode_region(
        input int unsigned addr,
        input int unsigned rom_depth,
        input int unsigned ram_base,
        input int unsigned ram_depth
    );
        if (addr < rom_depth) begin
            return REG_ROM;
        end else if ((addr >= ram_base) && (addr < ram_base + ram_depth)) begin
            return REG_RAM;
        end else begin
            return REG_UNMAPPED;
        end
    endfunction

endpackage

// File: rtl/mcu_mem_init_seq.sv
// rtl/mcu_mem_init_seq.sv - INIT/RUN sequencer that walks the data RAM through its default table
// Ports: clk, reset (sync, active-high), init_req (restart pulse),
//        ready (RUN state), init_we (RAM write port owned by the sequencer), init_idx (RAM word being filled)
module mcu_mem_init_seq
    import mcu_mem_pkg::*;
#(
    parameter int RAM_DEPTH = 6,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init_req,
    output logic             ready,
    output logic             init_we,
    output logic [IDX_W-1:0] init_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RAM_DEPTH - 1);

    mem_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            INIT: begin
                if (init_req) begin
                    idx_d = '0;
                end else if (idx_q == LAST_IDX) begin
                    // Last word is written on this edge, so RUN starts right after it.
                    state_d = RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            RUN: begin
                if (init_req) begin
                    state_d = INIT;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                idx_d   = '0;
            end
        endcase
    end

    assign ready    = (state_q == RUN);
    assign init_we  = (state_q == INIT);
    assign init_idx = idx_q;

endmodule

// File: rtl/mcu_mem_ctrl.sv
// rtl/mcu_mem_ctrl.sv - unified program ROM / data RAM with registered read and address-error pulse
// Ports: clk, reset (sync, active-high), init_req (restart RAM init),
//        READ/WRITE/MEM_ADDR/MEM_DATA1 (request), MEM_DATA2 (registered read data),
//        ready (requests accepted), rd_valid (read data updated last edge), addr_err (illegal access pulse)
module mcu_mem_ctrl
    import mcu_mem_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 5,
    parameter int ROM_DEPTH = 14,
    parameter int RAM_BASE  = 26,
    parameter int RAM_DEPTH = 6,
    parameter logic [ROM_DEPTH*DATA_W-1:0] ROM_IMAGE = DEF_ROM,
    parameter logic [RAM_DEPTH*DATA_W-1:0] RAM_INIT  = DEF_RAM_INIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_req,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_DATA1,
    output logic [DATA_W-1:0] MEM_DATA2,
    output logic              ready,
    output logic              rd_valid,
    output logic              addr_err
);

    localparam int IDX_W  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int ROM_AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] RAM_BASE_A = ADDR_W'(RAM_BASE);

    generate
        if (ROM_DEPTH > RAM_BASE) begin : g_chk_rom
            $fatal(1, "mcu_mem_ctrl: ROM overlaps RAM");
        end
        if (RAM_BASE + RAM_DEPTH > 2**ADDR_W) begin : g_chk_ram
            $fatal(1, "mcu_mem_ctrl: RAM exceeds address space");
        end
        if (RAM_DEPTH < 1) begin : g_chk_depth
            $fatal(1, "mcu_mem_ctrl: RAM_DEPTH must be at least 1");
        end
    endgenerate

    logic [DATA_W-1:0] rom_w  [ROM_DEPTH];
    logic [DATA_W-1:0] init_w [RAM_DEPTH];

    for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
        assign rom_w[i] = ROM_IMAGE[i*DATA_W +: DATA_W];
    end
    for (genvar i = 0; i < RAM_DEPTH; i++) begin : g_init
        assign init_w[i] = RAM_INIT[i*DATA_W +: DATA_W];
    end

    logic             init_we;
    logic [IDX_W-1:0] init_idx;

    mcu_mem_init_seq #(
        .RAM_DEPTH (RAM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_init_seq (
        .clk      (clk),
        .reset    (reset),
        .init_req (init_req),
        .ready    (ready),
        .init_we  (init_we),
        .init_idx (init_idx)
    );

    logic [DATA_W-1:0] ram_q [RAM_DEPTH];
    logic [DATA_W-1:0] ram_d [RAM_DEPTH];
    logic [DATA_W-1:0] data_q, data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              addr_err_q, addr_err_d;

    mem_region_e       region;
    logic [ADDR_W-1:0] ram_off;
    logic [IDX_W-1:0]  ram_idx;
    logic              rd_acc;
    logic              wr_acc;

    assign region  = decode_region(32'(MEM_ADDR), ROM_DEPTH, RAM_BASE, RAM_DEPTH);
    assign ram_off = MEM_ADDR - RAM_BASE_A;
    assign ram_idx = ram_off[IDX_W-1:0];

    // init_req wins over a request in the same cycle; read wins over write.
    assign rd_acc = ready && !init_req && READ;
    assign wr_acc = ready && !init_req && WRITE && !READ;

    always_comb begin
        ram_d      = ram_q;
        data_d     = data_q;
        rd_valid_d = 1'b0;
        addr_err_d = 1'b0;

        if (init_we) begin
            ram_d[init_idx] = init_w[init_idx];
        end else if (wr_acc && (region == REG_RAM)) begin
            ram_d[ram_idx] = MEM_DATA1;
        end

        if (rd_acc) begin
            rd_valid_d = 1'b1;
            case (region)
                REG_ROM: data_d = rom_w[MEM_ADDR[ROM_AW-1:0]];
                REG_RAM: data_d = ram_q[ram_idx];
                default: begin
                    data_d     = '0;
                    addr_err_d = 1'b1;
                end
            endcase
        end

        if (wr_acc && (region != REG_RAM)) begin
            addr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    // RAM contents survive reset; the INIT pass rewrites them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ram_q <= ram_d;
        end
    end

    assign MEM_DATA2 = data_q;
    assign rd_valid  = rd_valid_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_mcu_mem_ctrl.sv
// tb/tb_mcu_mem_ctrl.sv - self-checking bench for mcu_mem_ctrl, default and widened configurations
module tb_mcu_mem_ctrl;

    localparam logic [63:0] B_RAM_INIT = {
        8'hA5, 8'h5A, 8'h01, 8'h01, 8'h00, 8'h0A, 8'h01, 8'h00
    };

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init_req = 1'b0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [5:0] addr6 = '0;
    logic [7:0] wdata = '0;

    logic [7:0] o_data  [2];
    logic       o_ready [2];
    logic       o_rv    [2];
    logic       o_err   [2];

    always #5 clk = ~clk;

    mcu_mem_ctrl dut_a (
        .clk       (clk),
        .reset     (reset),
        .init_req  (init_req),
        .READ      (rd),
        .WRITE     (wr),
        .MEM_ADDR  (addr6[4:0]),
        .MEM_DATA1 (wdata),
        .MEM_DATA2 (o_data[0]),
        .ready     (o_ready[0]),
        .rd_valid  (o_rv[0]),
        .addr_err  (o_err[0])
    );

    mcu_mem_ctrl #(
        .ADDR_W    (6),
        .RAM_BASE  (40),
        .RAM_DEPTH (8),
        .RAM_INIT  (B_RAM_INIT)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .init_req  (init_req),
        .READ      (rd),
        .WRITE     (wr),
        .MEM_ADDR  (addr6),
        .MEM_DATA1 (wdata),
        .MEM_DATA2 (o_data[1]),
        .ready     (o_ready[1]),
        .rd_valid  (o_rv[1]),
        .addr_err  (o_err[1])
    );

    // Reference model: memory map and timing as plain arithmetic.
    logic [7:0] rom_tab [14] = '{8'hBF, 8'h5E, 8'hDA, 8'hBF, 8'hDE, 8'hBA, 8'hDF,
                                 8'hBD, 8'h5B, 8'hDD, 8'h9C, 8'h20, 8'hE0, 8'h00};
    logic [7:0] init_tab [2][8] = '{'{8'h00, 8'h01, 8'h0A, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00},
                                    '{8'h00, 8'h01, 8'h0A, 8'h00, 8'h01, 8'h01, 8'h5A, 8'hA5}};
    int         p_base  [2] = '{26, 40};
    int         p_depth [2] = '{6, 8};

    logic [7:0] m_ram   [2][8];
    logic [7:0] m_data  [2];
    logic       m_rv    [2];
    logic       m_err   [2];
    int         m_left  [2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int a;
        a = (k == 0) ? int'(addr6[4:0]) : int'(addr6);
        if (reset) begin
            m_data[k] = 8'h00;
            m_rv[k]   = 1'b0;
            m_err[k]  = 1'b0;
            m_left[k] = p_depth[k];
        end else begin
            m_rv[k]  = 1'b0;
            m_err[k] = 1'b0;
            if (m_left[k] > 0) begin
                if (init_req) begin
                    m_left[k] = p_depth[k];
                end else begin
                    m_left[k]--;
                    if (m_left[k] == 0)
                        for (int i = 0; i < 8; i++) m_ram[k][i] = init_tab[k][i];
                end
            end else if (init_req) begin
                m_left[k] = p_depth[k];
            end else if (rd) begin
                m_rv[k] = 1'b1;
                if (a < 14) begin
                    m_data[k] = rom_tab[a];
                end else if (a >= p_base[k] && a < p_base[k] + p_depth[k]) begin
                    m_data[k] = m_ram[k][a - p_base[k]];
                end else begin
                    m_data[k] = 8'h00;
                    m_err[k]  = 1'b1;
                end
            end else if (wr) begin
                if (a >= p_base[k] && a < p_base[k] + p_depth[k])
                    m_ram[k][a - p_base[k]] = wdata;
                else
                    m_err[k] = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("dut%0d.MEM_DATA2", k), 32'(o_data[k]), 32'(m_data[k]));
            chk($sformatf("dut%0d.rd_valid", k), 32'(o_rv[k]), 32'(m_rv[k]));
            chk($sformatf("dut%0d.addr_err", k), 32'(o_err[k]), 32'(m_err[k]));
            chk($sformatf("dut%0d.ready", k), 32'(o_ready[k]), 32'(m_left[k] == 0));
        end
    endtask

    task automatic req(input logic r, input logic w, input int a, input logic [7:0] d);
        rd    = r;
        wr    = w;
        addr6 = 6'(a);
        wdata = d;
        step();
    endtask

    task automatic wait_ready();
        int n;
        n  = 0;
        rd = 1'b0;
        wr = 1'b0;
        while (!(o_ready[0] && o_ready[1]) && n < 30) begin
            step();
            n++;
        end
        if (n >= 30) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // 1: reset, then hold a ROM read through init
        reset = 1'b1;
        step();
        step();
        chk("t1_reset_data", 32'(o_data[0]), 32'h0);
        chk("t1_reset_ready", 32'(o_ready[0]), 32'h0);
        reset = 1'b0;
        rd    = 1'b1;
        addr6 = 6'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t1_ready_low", 32'(o_ready[0]), 32'h0);
        end
        step();
        chk("t1_ready_high", 32'(o_ready[0]), 32'h1);
        step();
        chk("t1_first_read", 32'(o_data[0]), 32'hBF);
        wait_ready();

        // 2: read default RAM image back-to-back
        for (int i = 0; i < 6; i++) begin
            req(1'b1, 1'b0, 26 + i, 8'h00);
            chk("t2_rd_valid", 32'(o_rv[0]), 32'h1);
        end
        for (int i = 0; i < 8; i++) req(1'b1, 1'b0, 40 + i, 8'h00);

        // 3: RAM write then read, ROM write dropped
        req(1'b0, 1'b1, 29, 8'h37);
        req(1'b1, 1'b0, 29, 8'h00);
        chk("t3_raw", 32'(o_data[0]), 32'h37);
        req(1'b0, 1'b1, 3, 8'h55);
        chk("t3_rom_wr_err", 32'(o_err[0]), 32'h1);
        req(1'b1, 1'b0, 3, 8'h00);
        chk("t3_rom_kept", 32'(o_data[0]), 32'hBF);

        // 4: unmapped read, read-priority collision
        req(1'b1, 1'b0, 20, 8'h00);
        chk("t4_unmapped_err", 32'(o_err[0]), 32'h1);
        req(1'b1, 1'b1, 28, 8'hFF);
        chk("t4_collide_rd", 32'(o_data[0]), 32'h0A);
        chk("t4_collide_err", 32'(o_err[0]), 32'h0);
        req(1'b1, 1'b0, 28, 8'h00);
        chk("t4_ram_kept", 32'(o_data[0]), 32'h0A);

        // 5: init_req discards a same-cycle read and reloads the RAM
        req(1'b0, 1'b1, 29, 8'h37);
        init_req = 1'b1;
        req(1'b1, 1'b0, 29, 8'h00);
        init_req = 1'b0;
        chk("t5_rd_ignored", 32'(o_rv[0]), 32'h0);
        for (int i = 0; i < 5; i++) req(1'b1, 1'b0, 29, 8'h00);
        chk("t5_still_init", 32'(o_ready[0]), 32'h0);
        wait_ready();
        req(1'b1, 1'b0, 29, 8'h00);
        chk("t5_reloaded", 32'(o_data[0]), 32'h00);

        // 6: reset mid-INIT and with rd_valid pending
        init_req = 1'b1;
        req(1'b0, 1'b0, 0, 8'h00);
        init_req = 1'b0;
        for (int i = 0; i < 3; i++) req(1'b0, 1'b0, 0, 8'h00);
        reset = 1'b1;
        req(1'b0, 1'b0, 0, 8'h00);
        reset = 1'b0;
        wait_ready();
        req(1'b1, 1'b0, 5, 8'h00);
        reset = 1'b1;
        req(1'b1, 1'b0, 5, 8'h00);
        chk("t6_rv_cancel", 32'(o_rv[0]), 32'h0);
        chk("t6_data_clear", 32'(o_data[0]), 32'h0);
        reset = 1'b0;
        wait_ready();

        // Randomised traffic on both configurations
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            init_req = ($urandom_range(0, 59) == 0);
            rd       = 1'($urandom_range(0, 1));
            wr       = 1'($urandom_range(0, 1));
            addr6    = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(24, 47)) : 6'($urandom);
            wdata    = 8'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
